// File: rtl/parity_serial_tx_if.sv
// parity_serial_tx_if: byte handshake and serial-line signals of parity_serial_tx.
// master: upstream producer / line observer; slave: the transmitter itself.
interface parity_serial_tx_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: accepts a byte on a valid/ready handshake and shifts out
// start, 8 data bits (LSB first), even parity and stop on a registered line.
// Optional feature macro: PARITY_SERIAL_TX_PARITY_EN (defined -> parity bit
// sent, 11-bit frames; undefined -> no parity logic, 10-bit frames).
module parity_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              areset,
  parity_serial_tx_if.slave bus
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  baud_q,  baud_d;
  logic [2:0]     bit_q,   bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q,    tx_d;
  logic           done_q,  done_d;
  logic           baud_tc;
`ifdef PARITY_SERIAL_TX_PARITY_EN
  logic           parity_q, parity_d;
`endif

  assign baud_tc = (baud_q == BAUD_LAST);

  // State register and datapath registers; async reset returns the idle line.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef PARITY_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef PARITY_SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state, baud/bit counting, shifting and the next line level.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    tx_d     = 1'b1;
`ifdef PARITY_SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Every bit period ends on the terminal count, so wrapping here also
    // zeroes the counter on each state change.
    if (state_q != IDLE) begin
      baud_d = baud_tc ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d  = START;
          shift_d  = bus.in_data;
          baud_d   = '0;
          bit_d    = '0;
`ifdef PARITY_SERIAL_TX_PARITY_EN
          parity_d = ^bus.in_data;
`endif
        end
      end
      START: begin
        if (baud_tc) state_d = DATA;
      end
      DATA: begin
        if (baud_tc) begin
          // 3-bit counter wraps back to 0 after bit 7.
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PARITY_SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef PARITY_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (baud_tc) state_d = STOP;
      end
`endif
      STOP: begin
        if (baud_tc) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level is decoded from the next state so the registered tx
    // changes on the same edge as the state, keeping tx glitch-free.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef PARITY_SERIAL_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.tx       = tx_q;
  assign bus.done     = done_q;

endmodule
